// File: rtl/amm_pkg.sv
// Shared constants and helpers for the Avalon-MM memory slave.
//   AMM_BYTE_W    : bits per byte lane
//   AMM_MAX_BYTES : widest byteenable the lane-mask helper supports
//   amm_lane_mask : expands a byteenable vector into a per-bit write mask
package amm_pkg;

  localparam int unsigned AMM_BYTE_W    = 8;
  localparam int unsigned AMM_MAX_BYTES = 64;
  localparam int unsigned AMM_CNT_W     = 32;

  // Callers zero-extend their byteenable to AMM_MAX_BYTES and truncate the
  // result back to their data width.
  function automatic logic [AMM_MAX_BYTES*AMM_BYTE_W-1:0] amm_lane_mask(
    input logic [AMM_MAX_BYTES-1:0] be
  );
    logic [AMM_MAX_BYTES*AMM_BYTE_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < AMM_MAX_BYTES; i++) begin
      m[i*AMM_BYTE_W +: AMM_BYTE_W] = {AMM_BYTE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/amm_stall_gen.sv
// Periodic waitrequest generator.
//   clk_i   : clock
//   srst_i  : asynchronous active-high reset
//   stall_o : high for one cycle in every PER cycles; PER = 0 never stalls
// The output is a register driven only by a free-running counter, so it has
// no dependency on request activity.
module amm_stall_gen #(
  parameter int unsigned PER = 0
) (
  input  logic clk_i,
  input  logic srst_i,
  output logic stall_o
);

  localparam int unsigned PER_EFF = (PER == 0) ? 1 : PER;
  localparam int unsigned CW      = (PER_EFF > 1) ? $clog2(PER_EFF) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_stall;

  always_comb begin
    w_cnt_nxt = (r_cnt == CW'(PER_EFF - 1)) ? '0 : r_cnt + CW'(1);
  end

  // r_stall is registered from the next count so it always equals
  // (r_cnt == PER-1) without a combinational compare on the output.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_stall <= (w_cnt_nxt == CW'(PER_EFF - 1));
    end
  end

  assign stall_o = (PER != 0) && r_stall;

endmodule

// File: rtl/amm_mem_slave.sv
// Dual-port Avalon-MM memory slave (read port A, write port B).
//   clk_i / srst_i                 : clock, asynchronous active-high reset
//   amm_rd_*                       : read port, fixed RD_LATENCY response
//   amm_wr_*                       : write port with byte-lane enables
//   rd_cnt_o / wr_cnt_o            : accepted reads / writes since reset
// Waitrequest on each port comes from a periodic stall generator.
module amm_mem_slave
  import amm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BYTE_CNT     = DATA_WIDTH / 8,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned RD_STALL_PER = 0,
  parameter int unsigned WR_STALL_PER = 0
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
  input  logic                  amm_rd_read_i,
  output logic                  amm_rd_waitrequest_o,
  output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
  output logic                  amm_rd_readdatavalid_o,
  input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
  input  logic                  amm_wr_write_i,
  input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
  output logic                  amm_wr_waitrequest_o,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_rd_stall;
  logic                  w_wr_stall;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] w_mask;

  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];
  logic [AMM_CNT_W-1:0]  r_rd_cnt;
  logic [AMM_CNT_W-1:0]  r_wr_cnt;

  amm_stall_gen #(.PER(RD_STALL_PER)) u_rd_stall (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .stall_o (w_rd_stall)
  );

  amm_stall_gen #(.PER(WR_STALL_PER)) u_wr_stall (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .stall_o (w_wr_stall)
  );

  assign w_rd_acc = amm_rd_read_i  & ~w_rd_stall;
  assign w_wr_acc = amm_wr_write_i & ~w_wr_stall;
  assign w_mask   = DATA_WIDTH'(amm_lane_mask(AMM_MAX_BYTES'(amm_wr_byteenable_i)));

  // Array is intentionally never reset; writes before a reset survive it.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      r_mem[amm_wr_address_i] <= (r_mem[amm_wr_address_i] & ~w_mask) |
                                 (amm_wr_writedata_i & w_mask);
    end
  end

  // Stage 0 captures the array with a non-blocking read, so a same-cycle
  // write to the same address is not yet visible (read-before-write).
  // Data only advances behind a valid bit, so the last stage holds the most
  // recent response between pulses.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= r_mem[amm_rd_address_i];
      end
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_acc) begin
        r_rd_cnt <= r_rd_cnt + AMM_CNT_W'(1);
      end
      if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + AMM_CNT_W'(1);
      end
    end
  end

  assign amm_rd_waitrequest_o   = w_rd_stall;
  assign amm_wr_waitrequest_o   = w_wr_stall;
  assign amm_rd_readdatavalid_o = r_vld[RD_LATENCY-1];
  assign amm_rd_readdata_o      = r_dat[RD_LATENCY-1];
  assign rd_cnt_o               = r_rd_cnt;
  assign wr_cnt_o               = r_wr_cnt;

endmodule

// File: tb/tb_amm_mem_slave.sv
// Bench for amm_mem_slave: instance 0 has no stalls, instance 1 uses
// RD_STALL_PER=3 / WR_STALL_PER=4 and is driven like byte_inc's masters.
module tb_amm_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic [9:0]  rd_addr [2];
  logic        rd_read [2];
  logic        rd_wait [2];
  logic [63:0] rd_data [2];
  logic        rd_vld [2];
  logic [9:0]  wr_addr [2];
  logic        wr_write [2];
  logic [63:0] wr_data [2];
  logic [7:0]  wr_be [2];
  logic        wr_wait [2];
  logic [31:0] rcnt [2];
  logic [31:0] wcnt [2];

  int checks   = 0;
  int failures = 0;

  amm_mem_slave #(
    .DATA_WIDTH(64), .ADDR_WIDTH(10), .RD_LATENCY(2),
    .RD_STALL_PER(0), .WR_STALL_PER(0)
  ) u_dut0 (
    .clk_i(clk), .srst_i(rst[0]),
    .amm_rd_address_i(rd_addr[0]), .amm_rd_read_i(rd_read[0]),
    .amm_rd_waitrequest_o(rd_wait[0]), .amm_rd_readdata_o(rd_data[0]),
    .amm_rd_readdatavalid_o(rd_vld[0]),
    .amm_wr_address_i(wr_addr[0]), .amm_wr_write_i(wr_write[0]),
    .amm_wr_writedata_i(wr_data[0]), .amm_wr_byteenable_i(wr_be[0]),
    .amm_wr_waitrequest_o(wr_wait[0]),
    .rd_cnt_o(rcnt[0]), .wr_cnt_o(wcnt[0])
  );

  amm_mem_slave #(
    .DATA_WIDTH(64), .ADDR_WIDTH(10), .RD_LATENCY(2),
    .RD_STALL_PER(3), .WR_STALL_PER(4)
  ) u_dut1 (
    .clk_i(clk), .srst_i(rst[1]),
    .amm_rd_address_i(rd_addr[1]), .amm_rd_read_i(rd_read[1]),
    .amm_rd_waitrequest_o(rd_wait[1]), .amm_rd_readdata_o(rd_data[1]),
    .amm_rd_readdatavalid_o(rd_vld[1]),
    .amm_wr_address_i(wr_addr[1]), .amm_wr_write_i(wr_write[1]),
    .amm_wr_writedata_i(wr_data[1]), .amm_wr_byteenable_i(wr_be[1]),
    .amm_wr_waitrequest_o(wr_wait[1]),
    .rd_cnt_o(rcnt[1]), .wr_cnt_o(wcnt[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the write until a non-stalled cycle, then release after the edge.
  task automatic wr(input int d, input logic [9:0] a, input logic [63:0] v, input logic [7:0] be);
    bit ok;
    @(negedge clk);
    wr_addr[d] = a; wr_data[d] = v; wr_be[d] = be; wr_write[d] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!wr_wait[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("wr_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 wr_write[d] = 1'b0;
  endtask

  // lat = number of negedges after the accept edge at which valid was seen.
  task automatic rd(input int d, input logic [9:0] a, output logic [63:0] v, output int lat);
    bit ok;
    @(negedge clk);
    rd_addr[d] = a; rd_read[d] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!rd_wait[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("rd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 rd_read[d] = 1'b0;
    lat = -1;
    v   = 'x;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rd_vld[d]) begin lat = k; v = rd_data[d]; break; end
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [9:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] v, nw;
    int          lat, nr, nwt;
    logic [63:0] pre [3];
    logic [63:0] post [3];

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd_addr[d] = '0; rd_read[d] = 1'b0;
      wr_addr[d] = '0; wr_write[d] = 1'b0; wr_data[d] = '0; wr_be[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdvalid", {63'd0, rd_vld[d]}, 64'd0);
      chk("rst_rddata",  rd_data[d], 64'd0);
      chk("rst_rdwait",  {63'd0, rd_wait[d]}, 64'd0);
      chk("rst_wrwait",  {63'd0, wr_wait[d]}, 64'd0);
      chk("rst_rdcnt",   {32'd0, rcnt[d]}, 64'd0);
      chk("rst_wrcnt",   {32'd0, wcnt[d]}, 64'd0);
    end
    @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;

    // ---------------- table-driven vectors on the unstalled instance
    tbl[0]  = '{1'b1, 10'h010, 64'h0011223344556677, 8'hFF, 64'h0};
    tbl[1]  = '{1'b0, 10'h010, 64'h0, 8'h00, 64'h0011223344556677};
    tbl[2]  = '{1'b1, 10'h010, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0};
    tbl[3]  = '{1'b0, 10'h010, 64'h0, 8'h00, 64'h00112233FFFFFFFF};
    tbl[4]  = '{1'b1, 10'h3FF, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0};
    tbl[5]  = '{1'b0, 10'h3FF, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D};
    tbl[6]  = '{1'b1, 10'h000, 64'h1122334455667788, 8'hFF, 64'h0};
    tbl[7]  = '{1'b1, 10'h000, 64'hAAAAAAAAAAAAAAAA, 8'h00, 64'h0};
    tbl[8]  = '{1'b0, 10'h000, 64'h0, 8'h00, 64'h1122334455667788};
    tbl[9]  = '{1'b1, 10'h000, 64'hAAAAAAAAAAAAAAAA, 8'h81, 64'h0};
    tbl[10] = '{1'b0, 10'h000, 64'h0, 8'h00, 64'hAA223344556677AA};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].is_wr) begin
        wr(0, tbl[i].addr, tbl[i].data, tbl[i].be);
      end else begin
        rd(0, tbl[i].addr, v, lat);
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
        chk($sformatf("vec%0d_data", i), v, tbl[i].exp);
      end
    end
    chk("vec_wrcnt", {32'd0, wcnt[0]}, 64'd6);
    chk("vec_rdcnt", {32'd0, rcnt[0]}, 64'd5);

    // ---------------- 8 back-to-back reads up to the last word
    for (int i = 0; i < 8; i++) wr(0, 10'(10'h3F8 + i), 64'hC0DE_0000_0000_03F8 + 64'(i), 8'hFF);
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    chk("b2b_rdcnt_after_rst", {32'd0, rcnt[0]}, 64'd0);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk($sformatf("b2b_valid_t%0d", t), {63'd0, rd_vld[0]}, {63'd0, (t >= 2 && t <= 9) ? 1'b1 : 1'b0});
      if (t >= 2 && t <= 9)
        chk($sformatf("b2b_data_t%0d", t), rd_data[0], 64'hC0DE_0000_0000_03F8 + 64'(t - 2));
      rd_read[0] = (t < 8);
      rd_addr[0] = 10'(10'h3F8 + t);
    end
    chk("b2b_rdcnt", {32'd0, rcnt[0]}, 64'd8);

    // ---------------- same-cycle read and write of 0x020
    wr(0, 10'h020, 64'h0, 8'hFF);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t >= 1)
        chk($sformatf("rbw_valid_t%0d", t), {63'd0, rd_vld[0]}, {63'd0, (t == 2 || t == 3) ? 1'b1 : 1'b0});
      if (t == 2) chk("rbw_old_data", rd_data[0], 64'h0);
      if (t == 3) chk("rbw_new_data", rd_data[0], 64'h5);
      rd_addr[0]  = 10'h020; rd_read[0] = (t < 2);
      wr_addr[0]  = 10'h020; wr_data[0] = 64'h5; wr_be[0] = 8'hFF;
      wr_write[0] = (t == 0);
    end

    // ---------------- reset right after two read accepts
    wr(0, 10'h030, 64'h0123456789ABCDEF, 8'hFF);
    @(negedge clk); rd_addr[0] = 10'h030; rd_read[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst[0] = 1'b1; rd_read[0] = 1'b0;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    nr = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (rd_vld[0]) nr++;
    end
    chk("rst_mid_no_valid", 64'(nr), 64'd0);
    chk("rst_mid_rdcnt", {32'd0, rcnt[0]}, 64'd0);
    chk("rst_mid_wrcnt", {32'd0, wcnt[0]}, 64'd0);
    rd(0, 10'h030, v, lat);
    chk("rst_mid_mem_kept", v, 64'h0123456789ABCDEF);

    // ---------------- stalled instance driven like byte_inc (base 0x10, 20 bytes)
    pre[0]  = 64'h0706050403020100; post[0] = 64'h0807060504030201;
    pre[1]  = 64'h0F0E0D0C0B0A0908; post[1] = 64'h100F0E0D0C0B0A09;
    pre[2]  = 64'hFFFEFDFC13121110; post[2] = 64'hFFFEFDFC14131211;
    for (int i = 0; i < 3; i++) wr(1, 10'(10'h010 + i), pre[i], 8'hFF);
    @(negedge clk); rst[1] = 1'b1;
    @(negedge clk); rst[1] = 1'b0;
    nr = 0; nwt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rd_wait[1]) nr++;
      if (wr_wait[1]) nwt++;
    end
    chk("stall_rd_count", 64'(nr), 64'd4);
    chk("stall_wr_count", 64'(nwt), 64'd3);
    for (int i = 0; i < 3; i++) begin
      rd(1, 10'(10'h010 + i), v, lat);
      chk($sformatf("inc_rd%0d_latency", i), 64'(lat), 64'd2);
      for (int b = 0; b < 8; b++) nw[b*8 +: 8] = v[b*8 +: 8] + 8'd1;
      wr(1, 10'(10'h010 + i), nw, (i == 2) ? 8'h0F : 8'hFF);
    end
    chk("inc_rdcnt", {32'd0, rcnt[1]}, 64'd3);
    chk("inc_wrcnt", {32'd0, wcnt[1]}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      rd(1, 10'(10'h010 + i), v, lat);
      chk($sformatf("inc_word%0d", i), v, post[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
